// File: rtl/shift_reg_ctrl_if.sv
// Handshake/data bundle for the universal shift register.
// The master drives the controls and the slave (the register) drives the results.
interface shift_reg_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             enable;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output enable, mode, d, ser_in, start, amount,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  enable, mode, d, ser_in, start, amount,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Universal WIDTH-bit shift register with single-step ops and an autonomous
// N-step burst engine driven by a start/busy/done handshake.
module shift_reg_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic            clk,
  input logic            rst_n,
  shift_reg_ctrl_if.slave bus
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_r, state_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic             ser_r, ser_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       mode_r, mode_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [2:0]       op_sel_s;
  logic [WIDTH:0]   step_s;

  // One step of an operation; result is {new ser_out, new q}.
  function automatic logic [WIDTH:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur_q,
    input logic             cur_ser,
    input logic             fill,
    input logic [WIDTH-1:0] load_d
  );
    logic [WIDTH:0] res;
    case (op)
      OP_LOAD: res = {cur_ser, load_d};
      OP_SHL:  res = {cur_q[WIDTH-1], cur_q[WIDTH-2:0], fill};
      OP_SHR:  res = {cur_q[0], fill, cur_q[WIDTH-1:1]};
      OP_ROL:  res = {cur_q[WIDTH-1], cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
      OP_ROR:  res = {cur_q[0], cur_q[0], cur_q[WIDTH-1:1]};
      OP_ASR:  res = {cur_q[0], cur_q[WIDTH-1], cur_q[WIDTH-1:1]};
      default: res = {cur_ser, cur_q};
    endcase
    return res;
  endfunction

  // Only the five shifting modes may launch a burst.
  function automatic logic is_shift(input logic [2:0] op);
    logic res;
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: res = 1'b1;
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_s  = state_r;
    q_s      = q_r;
    ser_s    = ser_r;
    cnt_s    = cnt_r;
    mode_s   = mode_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    // During a burst the latched mode drives the datapath, not the live input.
    op_sel_s = (state_r == ST_SHIFT) ? mode_r : bus.mode;
    step_s   = apply_op(op_sel_s, q_r, ser_r, bus.ser_in, bus.d);

    if (bus.enable) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && is_shift(bus.mode)) begin
            mode_s = bus.mode;
            cnt_s  = bus.amount;
            if (bus.amount != {CNT_W{1'b0}}) begin
              state_s = ST_SHIFT;
              busy_s  = 1'b1;
            end else begin
              done_s = 1'b1;
            end
          end else begin
            {ser_s, q_s} = step_s;
          end
        end
        ST_SHIFT: begin
          {ser_s, q_s} = step_s;
          cnt_s        = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            busy_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end
      endcase
    end else begin
      done_s = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      q_r     <= {WIDTH{1'b0}};
      ser_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      mode_r  <= OP_HOLD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      ser_r   <= ser_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.q       = q_r;
  assign bus.ser_out = ser_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

  shift_reg_ctrl_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy_r),
    .done  (done_r)
  );

endmodule

// Handshake invariants of the burst engine.
module shift_reg_ctrl_chk (
  input logic clk,
  input logic rst_n,
  input logic busy,
  input logic done
);
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) !(done && busy));
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Randomized plus directed bench for shift_reg_ctrl against an arithmetic
// reference model that is compared on every falling clock edge.
module tb_shift_reg_ctrl;
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, ASR = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  shift_reg_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus ();

  shift_reg_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: values as integers, burst as a remaining-step count.
  logic [7:0] m_q;
  logic       m_ser, m_busy, m_done;
  logic [2:0] m_op;
  int         m_rem;

  function automatic logic [8:0] step(input logic [2:0] op, input logic [7:0] q,
                                      input logic s, input logic si, input logic [7:0] dd);
    int v = int'(q);
    int f = int'(si);
    case (op)
      LOAD:    return {s, dd};
      SHL:     return {1'(v / 128), 8'((v * 2 + f) % 256)};
      SHR:     return {1'(v % 2), 8'(v / 2 + f * 128)};
      ROL:     return {1'(v / 128), 8'((v * 2) % 256 + v / 128)};
      ROR:     return {1'(v % 2), 8'(v / 2 + (v % 2) * 128)};
      ASR:     return {1'(v % 2), 8'(v / 2 + (v / 128) * 128)};
      default: return {s, q};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 8'h00; m_ser <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      m_op <= HOLD; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (bus.enable) begin
        if (!m_busy) begin
          if (bus.start && bus.mode >= SHL && bus.mode <= ASR) begin
            m_op <= bus.mode;
            if (bus.amount == 4'd0) m_done <= 1'b1;
            else begin
              m_busy <= 1'b1;
              m_rem  <= int'(bus.amount);
            end
          end else begin
            {m_ser, m_q} <= step(bus.mode, m_q, m_ser, bus.ser_in, bus.d);
          end
        end else begin
          {m_ser, m_q} <= step(m_op, m_q, m_ser, bus.ser_in, bus.d);
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of DUT against model.
  always @(negedge clk) begin
    check("q", 32'(bus.q), 32'(m_q));
    check("ser_out", 32'(bus.ser_out), 32'(m_ser));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
  end

  task automatic drive(input logic en, input logic [2:0] md, input logic [7:0] dd,
                       input logic si, input logic st, input logic [3:0] amt);
    bus.enable = en; bus.mode = md; bus.d = dd;
    bus.ser_in = si; bus.start = st; bus.amount = amt;
    @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_q"}, 32'(bus.q), 32'h0);
    check({tag, "_ser"}, 32'(bus.ser_out), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int busy_cnt, done_cnt;
  logic [0:5] en_pat;

  initial begin
    bus.enable = 1'b0; bus.mode = HOLD; bus.d = 8'h00;
    bus.ser_in = 1'b0; bus.start = 1'b0; bus.amount = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_q", 32'(bus.q), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;

    // Single step
    drive(1'b1, LOAD, 8'hA5, 1'b0, 1'b0, 4'd0);
    drive(1'b1, SHL, 8'h00, 1'b1, 1'b0, 4'd0);
    check("single_q", 32'(bus.q), 32'h4B);
    check("single_ser", 32'(bus.ser_out), 32'h1);
    check("single_busy", 32'(bus.busy), 32'h0);

    // Rotate burst with toggling inputs
    drive(1'b1, LOAD, 8'h81, 1'b0, 1'b0, 4'd0);
    drive(1'b1, ROL, 8'h00, 1'b0, 1'b1, 4'd3);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      busy_cnt += int'(bus.busy); done_cnt += int'(bus.done);
      drive(1'b1, (i < 3) ? 3'($urandom_range(0, 7)) : HOLD, 8'($urandom),
            1'($urandom), 1'b0, 4'($urandom));
    end
    check("rol_busy_cycles", 32'(busy_cnt), 32'd3);
    check("rol_done_pulses", 32'(done_cnt), 32'd1);
    check("rol_q", 32'(bus.q), 32'h0C);
    check("rol_ser", 32'(bus.ser_out), 32'h0);

    // Paused asr burst
    drive(1'b1, LOAD, 8'h90, 1'b0, 1'b0, 4'd0);
    drive(1'b1, ASR, 8'h00, 1'b0, 1'b1, 4'd2);
    en_pat = 6'b100111;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      busy_cnt += int'(bus.busy); done_cnt += int'(bus.done);
      drive(en_pat[i], HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
    end
    check("asr_busy_cycles", 32'(busy_cnt), 32'd4);
    check("asr_done_pulses", 32'(done_cnt), 32'd1);
    check("asr_q", 32'(bus.q), 32'hE4);

    // Zero burst, then burst with start re-asserted while busy
    drive(1'b1, SHR, 8'h00, 1'b0, 1'b1, 4'd0);
    check("zero_done", 32'(bus.done), 32'h1);
    check("zero_busy", 32'(bus.busy), 32'h0);
    check("zero_q", 32'(bus.q), 32'hE4);
    drive(1'b1, HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
    check("zero_done_clear", 32'(bus.done), 32'h0);
    drive(1'b1, SHL, 8'h00, 1'b1, 1'b1, 4'd5);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      busy_cnt += int'(bus.busy); done_cnt += int'(bus.done);
      drive(1'b1, (i < 4) ? SHL : HOLD, 8'($urandom), 1'b1, (i < 4), 4'd3);
    end
    check("restart_busy_cycles", 32'(busy_cnt), 32'd5);
    check("restart_done_pulses", 32'(done_cnt), 32'd1);
    check("restart_q", 32'(bus.q), 32'h9F);

    // Long shifts
    drive(1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 4'd0);
    drive(1'b1, SHL, 8'h00, 1'b0, 1'b1, 4'd9);
    repeat (10) drive(1'b1, HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
    check("long_shl_q", 32'(bus.q), 32'h00);
    drive(1'b1, LOAD, 8'h01, 1'b0, 1'b0, 4'd0);
    drive(1'b1, ROR, 8'h00, 1'b0, 1'b1, 4'd9);
    repeat (10) drive(1'b1, HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
    check("long_ror_q", 32'(bus.q), 32'h80);

    // Asynchronous reset in the middle of a burst
    drive(1'b1, LOAD, 8'h5A, 1'b1, 1'b0, 4'd0);
    drive(1'b1, ROL, 8'h00, 1'b0, 1'b1, 4'd7);
    drive(1'b1, HOLD, 8'h00, 1'b0, 1'b0, 4'd0);
    async_reset_check("rst_mid_burst");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 4)));
      if ($urandom_range(0, 499) == 0) async_reset_check("rst_random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
